// File: rtl/uart_tx_fc.sv
// uart_tx_fc: UART transmitter with CTS flow control and a programmable baud divider.
// Define UART_TX_PARITY_EN to add a parity slot and the uart_tx_parity_odd input.
module uart_tx_fc #(
  parameter int COUNT_REG_LEN = 13,
  parameter int PAYLOAD_BITS  = 8,
  parameter int STOP_BITS     = 1
) (
  input  logic                     clk,
  input  logic                     resetn,
  output logic                     uart_txd,
  input  logic                     uart_cts,
  input  logic                     uart_tx_start,
  input  logic [PAYLOAD_BITS-1:0]  uart_tx_data,
`ifdef UART_TX_PARITY_EN
  input  logic                     uart_tx_parity_odd,
`endif
  output logic                     uart_tx_busy,
  input  logic [COUNT_REG_LEN-1:0] baud_divider
);
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
`ifdef UART_TX_PARITY_EN
    , PARITY
`endif
  } state_t;
  localparam logic [3:0] LAST_D = 4'(PAYLOAD_BITS - 1);
  localparam logic [3:0] LAST_S = 4'(STOP_BITS - 1);
  state_t state, state_n;
  logic [COUNT_REG_LEN-1:0] cnt, cnt_n;
  logic [3:0] idx, idx_n;
  logic [PAYLOAD_BITS-1:0] sh, sh_n;
  logic par, par_n, txd_n, busy_n;
  logic [1:0] cts_s;
  logic cts_ok, bit_end;
  assign cts_ok = ~cts_s[1];
  assign bit_end = cnt >= baud_divider;
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
      cnt <= '0;
      idx <= '0;
      sh <= '0;
      par <= 1'b0;
      uart_txd <= 1'b1;
      uart_tx_busy <= 1'b0;
      cts_s <= 2'b11;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      idx <= idx_n;
      sh <= sh_n;
      par <= par_n;
      uart_txd <= txd_n;
      uart_tx_busy <= busy_n;
      cts_s <= {cts_s[0], uart_cts};
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = '0;
    idx_n = idx;
    sh_n = sh;
    par_n = par;
    txd_n = uart_txd;
    busy_n = uart_tx_busy;
    if (state == IDLE) begin
      if (uart_tx_start && cts_ok) begin
        state_n = START;
        sh_n = uart_tx_data;
`ifdef UART_TX_PARITY_EN
        par_n = ^uart_tx_data ^ uart_tx_parity_odd;
`else
        par_n = ^uart_tx_data;
`endif
        txd_n = 1'b0;
        busy_n = 1'b1;
      end
    end else begin
      cnt_n = bit_end ? '0 : cnt + COUNT_REG_LEN'(1);
      // Each slot's level is driven on the same edge that ends the previous slot.
      if (bit_end) begin
        case (state)
          START: begin
            state_n = DATA;
            txd_n = sh[0];
            sh_n = sh >> 1;
            idx_n = '0;
          end
          DATA: begin
            if (idx == LAST_D) begin
`ifdef UART_TX_PARITY_EN
              state_n = PARITY;
              txd_n = par;
`else
              state_n = STOP;
              txd_n = 1'b1;
              idx_n = '0;
`endif
            end else begin
              txd_n = sh[0];
              sh_n = sh >> 1;
              idx_n = idx + 4'd1;
            end
          end
`ifdef UART_TX_PARITY_EN
          PARITY: begin
            state_n = STOP;
            txd_n = 1'b1;
            idx_n = '0;
          end
`endif
          STOP: begin
            txd_n = 1'b1;
            if (idx == LAST_S) begin
              state_n = IDLE;
              busy_n = 1'b0;
            end else begin
              idx_n = idx + 4'd1;
            end
          end
          default: begin
            state_n = IDLE;
            txd_n = 1'b1;
            busy_n = 1'b0;
          end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_fc.sv
// tb_uart_tx_fc: directed and randomized frames checked against an expected bit-list model.
module tb_uart_tx_fc;
  logic clk = 1'b0;
  logic resetn, txd, cts, start, busy;
  logic [7:0] data;
  logic [12:0] baud;
`ifdef UART_TX_PARITY_EN
  logic odd;
`endif
  int checks = 0;
  int failures = 0;

  uart_tx_fc dut (
    .clk(clk),
    .resetn(resetn),
    .uart_txd(txd),
    .uart_cts(cts),
    .uart_tx_start(start),
    .uart_tx_data(data),
`ifdef UART_TX_PARITY_EN
    .uart_tx_parity_odd(odd),
`endif
    .uart_tx_busy(busy),
    .baud_divider(baud)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; strobes start, then checks every cycle of the frame.
  // At cycle 'poke' of the frame a second strobe (0xFF) is raised and CTS dropped.
  task automatic frame(input logic [7:0] d, input int div, input logic od, input int poke);
    logic q[$];
    int n = 0;
    q.push_back(1'b0);
    for (int i = 0; i < 8; i++) q.push_back(d[i]);
`ifdef UART_TX_PARITY_EN
    q.push_back(1'(($countones(d) & 1) ^ int'(od)));
    odd = od;
`else
    if (od) n = 0;
`endif
    q.push_back(1'b1);
    baud = 13'(div);
    data = d;
    start = 1'b1;
    @(negedge clk);
    foreach (q[s]) begin
      for (int c = 0; c <= div; c++) begin
        if (n == poke) begin
          start = 1'b1;
          data = 8'hFF;
          cts = 1'b1;
        end else start = 1'b0;
        chk($sformatf("txd d=%0h slot=%0d cyc=%0d", d, s, c), 32'(txd), 32'(q[s]));
        chk($sformatf("busy d=%0h slot=%0d cyc=%0d", d, s, c), 32'(busy), 32'd1);
        n++;
        @(negedge clk);
      end
    end
    start = 1'b0;
    chk($sformatf("end_busy d=%0h", d), 32'(busy), 32'd0);
    chk($sformatf("end_txd d=%0h", d), 32'(txd), 32'd1);
  endtask

  initial begin
    resetn = 1'b0;
    cts = 1'b0;
    start = 1'b0;
    data = 8'h00;
    baud = 13'd4;
`ifdef UART_TX_PARITY_EN
    odd = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk("reset_txd", 32'(txd), 32'd1);
    chk("reset_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    frame(8'hA5, 4, 1'b0, -1);
    cts = 1'b1;
    repeat (3) @(negedge clk);
    data = 8'h3C;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("cts_block_txd", 32'(txd), 32'd1);
      chk("cts_block_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    cts = 1'b0;
    repeat (2) @(negedge clk);
    frame(8'h3C, 4, 1'b0, -1);
    @(negedge clk);
    frame(8'h55, 2, 1'b0, 7);
    for (int i = 0; i < 6; i++) begin
      chk("dropped_txd", 32'(txd), 32'd1);
      chk("dropped_busy", 32'(busy), 32'd0);
      @(negedge clk);
    end
    cts = 1'b0;
    repeat (2) @(negedge clk);
    frame(8'h01, 0, 1'b0, -1);
    frame(8'h80, 0, 1'b0, -1);
    baud = 13'd3;
    data = 8'h00;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (17) @(negedge clk);
    chk("midframe_bit3", 32'(txd), 32'd0);
    chk("midframe_busy", 32'(busy), 32'd1);
    resetn = 1'b0;
    @(negedge clk);
    chk("midreset_txd", 32'(txd), 32'd1);
    chk("midreset_busy", 32'(busy), 32'd0);
    resetn = 1'b1;
    repeat (3) @(negedge clk);
    frame(8'hF0, 3, 1'b0, -1);
    @(negedge clk);
    frame(8'h07, 2, 1'b0, -1);
    @(negedge clk);
    frame(8'h07, 2, 1'b1, -1);
    for (int k = 0; k < 8; k++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      frame(8'($urandom), int'($urandom_range(0, 5)), 1'($urandom_range(0, 1)), -1);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/uart_tx_fc.md
Name: uart_tx_fc

Overview:
- UART transmitter peripheral core: serialises one payload word per frame onto `uart_txd`.
- Frame format: start bit, data LSB first, optional parity, stop bit(s).
- Bit timing comes from a programmable baud divider.
- Flow control: honours an active-low CTS input.
- Sits beside the UART receiver in the user peripheral block; driven by the CPU register interface through a single-cycle start strobe and a busy flag.

Parameters:
- COUNT_REG_LEN, 13: width of the cycle counter and `baud_divider` (9600 baud at 64 MHz).
- PAYLOAD_BITS, 8: data bits per frame, 1..8.
- STOP_BITS, 1: stop bits per frame, 1 or 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- resetn  input  1  reset; synchronous, active-low.
- uart_txd  output  1  serial output; idles high.
- uart_cts  input  1  clear-to-send, active low; asynchronous, so it is synchronised internally.
- uart_tx_start  input  1  single-cycle request to transmit `uart_tx_data`.
- uart_tx_data  input  PAYLOAD_BITS  word to send; sampled only on accept.
- uart_tx_busy  output  1  high while a frame is in flight.
- baud_divider  input  COUNT_REG_LEN  bit period minus one, in clk cycles.

Behaviour:
- Reset values: `uart_txd`=1, `uart_tx_busy`=0, FSM=IDLE, cycle counter=0, CTS synchroniser flops=1 (not clear).
- Registered outputs: `uart_txd` and `uart_tx_busy` are registered; no combinational path from any input to any output.
- CTS synchroniser: two-flop; `cts_ok` = synchronised `uart_cts` == 0. A CTS change is visible after 2 clk edges.
- Accept condition: FSM==IDLE && `uart_tx_start` && `cts_ok`.
- On the accept edge:
  - latch `uart_tx_data` into the shift register;
  - load cycle counter with 0;
  - FSM -> START;
  - `uart_txd` <= 0;
  - `uart_tx_busy` <= 1.
- `uart_tx_start` ignored when not accepted:
  - when busy or when CTS is not clear, the strobe is dropped, not queued;
  - the CPU must retry.
- FSM states: IDLE -> START -> DATA (PAYLOAD_BITS bit slots) -> [PARITY] -> STOP (STOP_BITS slots) -> IDLE.
- Bit timing:
  - counter increments each cycle and wraps to 0 when counter >= `baud_divider`;
  - `bit_end` is that wrap condition;
  - every bit slot lasts exactly `baud_divider`+1 cycles;
  - `baud_divider`=0 gives 1 cycle per bit.
- Serialisation:
  - on each `bit_end`, advance to the next slot and drive its level on the same edge;
  - data is shifted out LSB first;
  - STOP drives 1.
- Frame end and back-to-back frames:
  - on `bit_end` of the last stop slot: FSM -> IDLE, `uart_tx_busy` <= 0, `uart_txd` stays 1;
  - the earliest next accept is the following cycle;
  - minimum frame length is (1+PAYLOAD_BITS+[1]+STOP_BITS)*(`baud_divider`+1) cycles, measured from the first cycle `uart_txd`=0 to the first cycle `uart_tx_busy`=0.
- CTS mid-frame: deasserting CTS does not abort or stall a frame in progress; it only blocks the next accept.
- `baud_divider` changed mid-frame:
  - the live value is used;
  - because the compare is >=, a reduced divider ends the current slot on the next cycle and never hangs;
  - software is required not to change it while busy.
- Reset mid-frame: on the next edge `uart_txd`=1 and `uart_tx_busy`=0; the partial frame is abandoned; no glitch low.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - adds input port `uart_tx_parity_odd` (1 bit), sampled on accept;
  - a PARITY slot is inserted between DATA and STOP;
  - the parity bit = XOR of the data bits, XOR `uart_tx_parity_odd`. This gives even parity when 0 and odd parity when 1;
  - frame is one bit longer.
- Undefined: the port is absent, there is no PARITY state, and the frame is 8N1/8N2.

Test Plan:
- 8N1, divider=4, CTS=0, start with data 0xA5:
  - `uart_txd` = 0, 1,0,1,0,0,1,0,1, then 1, each level held 5 cycles;
  - busy is high for exactly 50 cycles.
- CTS=1 (held >=2 cycles), start pulsed with 0x3C:
  - no accept, `uart_txd` stays 1, busy stays 0;
  - CTS=0 then start again: frame for 0x3C begins 1 cycle after the strobe edge.
- Mid-frame strobes: during a 0x55 frame, pulse start with 0xFF and drop CTS:
  - the 0x55 frame completes unaltered;
  - 0xFF is never sent.
- Back-to-back, divider=0: start 0x01 and re-strobe on the first cycle busy=0 with 0x80.
  - Result: two contiguous 10-cycle frames, with only 1 idle-high cycle between the stop bit and the next start bit.
- Reset mid-frame: assert resetn=0 during data bit 3 of a 0x00 frame:
  - next edge `uart_txd`=1, busy=0;
  - after release, a new 0xF0 frame sends correctly.
- With UART_TX_PARITY_EN, divider=2:
  - data 0x07, odd=0: parity bit 1;
  - data 0x07, odd=1: parity bit 0;
  - frame = 11 bits * 3 cycles = 33 cycles.
